// File: rtl/tft_draw_arb.sv
// -----------------------------------------------------------------------------
// tft_draw_arb
//
// Purpose:
//   Arbitrates two draw requesters onto a single TFT controller. After reset,
//   or on a reinit request, it runs the controller's init sequence. It then
//   grants draw requests one at a time. Ties are broken round-robin. A fixed
//   2-cycle gap follows every controller completion, so the controller can
//   return to idle before the next command.
//
// Configuration:
//   TFT_DRAW_ARB_CLIP_EN - when defined, xend/yend are clamped to
//                          CLIP_XMAX/CLIP_YMAX. An empty rectangle after
//                          clamping is rejected with ack+err and no draw.
//                          When undefined, rectangles pass unmodified and
//                          err is tied low.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req[1:0]              level draw requests, held until ack
//   rect0, rect1          {xstart,xend,ystart,yend}, 16-bit fields, MSB first
//   color0, color1        RGB565 color of each requester
//   gnt[1:0]              one-hot grant, high while a draw is in flight
//   ack[1:0]              one-cycle completion/reject pulse per requester
//   err                   qualifies ack: request was rejected
//   cnext_o[1:0]          controller cnext routed to the granted requester
//   reinit                one-cycle pulse requesting a fresh init sequence
//   ready                 idle with init complete and no reinit pending
//   tft_init, tft_draw    one-cycle command pulses to the controller
//   tft_xstart..tft_yend  registered rectangle to the controller
//   tft_color             color of the granted requester
//   tft_busy, tft_done,   controller status (busy is informational only)
//   tft_cnext
// -----------------------------------------------------------------------------
module tft_draw_arb #(
    parameter logic [15:0] CLIP_XMAX = 16'd239,
    parameter logic [15:0] CLIP_YMAX = 16'd319
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [63:0] rect0,
    input  logic [63:0] rect1,
    input  logic [15:0] color0,
    input  logic [15:0] color1,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic        err,
    output logic [1:0]  cnext_o,
    input  logic        reinit,
    output logic        ready,
    output logic        tft_init,
    output logic        tft_draw,
    output logic [15:0] tft_xstart,
    output logic [15:0] tft_xend,
    output logic [15:0] tft_ystart,
    output logic [15:0] tft_yend,
    output logic [15:0] tft_color,
    input  logic        tft_busy,
    input  logic        tft_done,
    input  logic        tft_cnext
);

    typedef enum logic [2:0] {
        BOOT,
        INITWAIT,
        GAP,
        IDLE,
        DRAWWAIT
    } state_t;

    state_t      state_q, state_d;
    logic        gap_q, gap_d;        // second GAP cycle marker
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ack_q, ack_d;
    logic        gidx_q, gidx_d;      // index of the granted requester
    logic        last_q, last_d;      // last-served requester
    logic        reinit_q, reinit_d;  // latched reinit request
    logic        init_q, init_d;
    logic        draw_q, draw_d;
    logic [15:0] xs_q, xs_d;
    logic [15:0] xe_q, xe_d;
    logic [15:0] ys_q, ys_d;
    logic [15:0] ye_q, ye_d;

    logic        sel;
    logic [63:0] rect_sel;
    logic [15:0] xs_c, xe_c, ys_c, ye_c;

`ifdef TFT_DRAW_ARB_CLIP_EN
    logic        rej_q, rej_d;        // granted rectangle was empty
    logic        err_q, err_d;
    logic        bad_rect;
`endif

    // Requester selection and (optional) clipping of the selected rectangle.
    always_comb begin
        // A tie goes to whoever was not served last; otherwise take the
        // only requester present.
        sel      = (req == 2'b11) ? ~last_q : req[1];
        rect_sel = sel ? rect1 : rect0;
        xs_c     = rect_sel[63:48];
        xe_c     = rect_sel[47:32];
        ys_c     = rect_sel[31:16];
        ye_c     = rect_sel[15:0];
`ifdef TFT_DRAW_ARB_CLIP_EN
        if (xe_c > CLIP_XMAX) xe_c = CLIP_XMAX;
        if (ye_c > CLIP_YMAX) ye_c = CLIP_YMAX;
        bad_rect = (xs_c > xe_c) || (ys_c > ye_c);
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        gnt_d    = gnt_q;
        ack_d    = 2'b00;
        gidx_d   = gidx_q;
        last_d   = last_q;
        reinit_d = reinit_q | reinit;
        init_d   = 1'b0;
        draw_d   = 1'b0;
        xs_d     = xs_q;
        xe_d     = xe_q;
        ys_d     = ys_q;
        ye_d     = ye_q;
`ifdef TFT_DRAW_ARB_CLIP_EN
        rej_d    = rej_q;
        err_d    = 1'b0;
`endif

        case (state_q)
            BOOT: begin
                init_d  = 1'b1;
                state_d = INITWAIT;
            end

            INITWAIT: begin
                if (tft_done) begin
                    gap_d   = 1'b0;
                    state_d = GAP;
                end
            end

            GAP: begin
                gap_d = 1'b1;
                if (gap_q) state_d = IDLE;
            end

            IDLE: begin
                if (reinit_q || reinit) begin
                    // A reinit arriving in this very cycle is consumed here.
                    reinit_d = 1'b0;
                    state_d  = BOOT;
                end else if (req != 2'b00) begin
                    gidx_d  = sel;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    xs_d    = xs_c;
                    xe_d    = xe_c;
                    ys_d    = ys_c;
                    ye_d    = ye_c;
                    state_d = DRAWWAIT;
`ifdef TFT_DRAW_ARB_CLIP_EN
                    rej_d  = bad_rect;
                    draw_d = ~bad_rect;
`else
                    draw_d = 1'b1;
`endif
                end
            end

            DRAWWAIT: begin
`ifdef TFT_DRAW_ARB_CLIP_EN
                if (rej_q) begin
                    // Rejected grant: no controller activity, so no gap.
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    gnt_d   = 2'b00;
                    last_d  = gidx_q;
                    rej_d   = 1'b0;
                    state_d = IDLE;
                end else
`endif
                if (tft_done) begin
                    ack_d   = gnt_q;
                    gnt_d   = 2'b00;
                    last_d  = gidx_q;
                    gap_d   = 1'b0;
                    state_d = GAP;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            gap_q    <= 1'b0;
            gnt_q    <= 2'b00;
            ack_q    <= 2'b00;
            gidx_q   <= 1'b0;
            last_q   <= 1'b1;
            reinit_q <= 1'b0;
            init_q   <= 1'b0;
            draw_q   <= 1'b0;
            xs_q     <= 16'd0;
            xe_q     <= 16'd0;
            ys_q     <= 16'd0;
            ye_q     <= 16'd0;
`ifdef TFT_DRAW_ARB_CLIP_EN
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            gidx_q   <= gidx_d;
            last_q   <= last_d;
            reinit_q <= reinit_d;
            init_q   <= init_d;
            draw_q   <= draw_d;
            xs_q     <= xs_d;
            xe_q     <= xe_d;
            ys_q     <= ys_d;
            ye_q     <= ye_d;
`ifdef TFT_DRAW_ARB_CLIP_EN
            rej_q    <= rej_d;
            err_q    <= err_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign tft_init   = init_q;
    assign tft_draw   = draw_q;
    assign tft_xstart = xs_q;
    assign tft_xend   = xe_q;
    assign tft_ystart = ys_q;
    assign tft_yend   = ye_q;
    assign ready      = (state_q == IDLE) && !reinit_q;
    assign cnext_o    = gnt_q & {2{tft_cnext}};
    assign tft_color  = gidx_q ? color1 : color0;
`ifdef TFT_DRAW_ARB_CLIP_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_tft_draw_arb.sv
module tb_tft_draw_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req;
    logic [63:0] rect0, rect1;
    logic [15:0] color0, color1;
    logic [1:0]  gnt, ack;
    logic        err;
    logic [1:0]  cnext_o;
    logic        reinit, ready, tft_init, tft_draw;
    logic [15:0] tft_xstart, tft_xend, tft_ystart, tft_yend, tft_color;
    logic        tft_busy, tft_done, tft_cnext;

    localparam logic [15:0] XMAX = 16'd239;
    localparam logic [15:0] YMAX = 16'd319;

    tft_draw_arb dut (
        .clk(clk), .rst(rst), .req(req), .rect0(rect0), .rect1(rect1),
        .color0(color0), .color1(color1), .gnt(gnt), .ack(ack), .err(err),
        .cnext_o(cnext_o), .reinit(reinit), .ready(ready),
        .tft_init(tft_init), .tft_draw(tft_draw),
        .tft_xstart(tft_xstart), .tft_xend(tft_xend),
        .tft_ystart(tft_ystart), .tft_yend(tft_yend), .tft_color(tft_color),
        .tft_busy(tft_busy), .tft_done(tft_done), .tft_cnext(tft_cnext)
    );

    typedef struct {
        int          idx;
        logic [15:0] xs, xe, ys, ye, col;
    } draw_t;
    typedef struct {
        int idx;
        bit err;
    } ack_t;

    draw_t draw_q[$];
    ack_t  ack_q[$];
    int    checks = 0;
    int    failures = 0;
    int    model_last = 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: round-robin choice from the set of pending requesters.
    function automatic int pick(input logic [1:0] pend);
        if (pend == 2'b11) return (model_last == 0) ? 1 : 0;
        return pend[1] ? 1 : 0;
    endfunction

    // Reference model: outcome of serving requester idx with rectangle r.
    task automatic push_exp(input int idx, input logic [63:0] r, input logic [15:0] c);
        draw_t d;
        ack_t  a;
        logic [15:0] xe, ye;
        bit rej;
        rej  = 1'b0;
        d.xs = r[63:48];
        xe   = r[47:32];
        d.ys = r[31:16];
        ye   = r[15:0];
`ifdef TFT_DRAW_ARB_CLIP_EN
        if (xe > XMAX) xe = XMAX;
        if (ye > YMAX) ye = YMAX;
        rej = (d.xs > xe) || (d.ys > ye);
`endif
        d.idx = idx;
        d.xe  = xe;
        d.ye  = ye;
        d.col = c;
        if (!rej) draw_q.push_back(d);
        a.idx = idx;
        a.err = rej;
        ack_q.push_back(a);
        model_last = idx;
    endtask

    function automatic logic [63:0] rnd_rect();
        logic [15:0] xs, xe, ys, ye;
        xs = 16'($urandom_range(0, 260));
        xe = 16'(xs + 16'($urandom_range(0, 80)));
        ys = 16'($urandom_range(0, 340));
        ye = 16'(ys + 16'($urandom_range(0, 80)));
        return {xs, xe, ys, ye};
    endfunction

    function automatic bit sig(input int w);
        case (w)
            0:       return tft_draw;
            1:       return tft_init;
            2:       return ready;
            default: return gnt == 2'b01;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sig(w)) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    // Requesters drop their request on the cycle ack is seen.
    task automatic drive_until_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
            if (req == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_done_timeout", ok, 1);
        req = 2'b00;
    endtask

    task automatic run_pattern(input logic [1:0] pat, input logic [63:0] r0, input logic [63:0] r1,
                               input logic [15:0] c0, input logic [15:0] c1);
        int first;
        rect0  = r0;
        rect1  = r1;
        color0 = c0;
        color1 = c1;
        first  = pick(pat);
        push_exp(first, first ? r1 : r0, first ? c1 : c0);
        if (pat == 2'b11) push_exp(1 - first, first ? r0 : r1, first ? c0 : c1);
        req = pat;
        drive_until_done();
    endtask

    // Behavioural TFT controller: answers each init/draw with one done pulse.
    task automatic ctrl_loop();
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            tft_done  = 1'b0;
            tft_cnext = 1'($urandom_range(0, 1));
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tft_done = 1'b1;
                end
                if (tft_draw || tft_init) cnt = $urandom_range(5, 12);
            end
            tft_busy = (cnt > 0);
        end
    endtask

    // Monitor: pops expectations whenever the DUT issues a draw or an ack.
    initial begin
        draw_t d;
        ack_t  a;
        int    since_ack;
        bit    last_err;
        since_ack = 100;
        last_err  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                since_ack = 100;
                continue;
            end
            since_ack++;
            chk("cnext_route", cnext_o, gnt & {2{tft_cnext}});
            if (tft_draw) begin
                if (draw_q.size() == 0) begin
                    chk("draw_unexpected", 1, 0);
                end else begin
                    d = draw_q.pop_front();
                    chk("draw_gnt", gnt, 64'd1 << d.idx);
                    chk("draw_xstart", tft_xstart, d.xs);
                    chk("draw_xend", tft_xend, d.xe);
                    chk("draw_ystart", tft_ystart, d.ys);
                    chk("draw_yend", tft_yend, d.ye);
                    chk("draw_color", tft_color, d.col);
                    if (!last_err) chk("draw_gap", since_ack >= 3, 1);
                end
            end
            if (ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_bit", ack, 64'd1 << a.idx);
                    chk("ack_err", err, a.err);
                    chk("ack_gnt_clear", gnt, 0);
                    last_err = a.err;
                end
                since_ack = 0;
            end else if (err) begin
                chk("err_without_ack", err, 0);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int ninit;
        bit saw_init;
        bit early_gnt;
        logic [63:0] ra, rb;

        rst = 1'b1; req = 2'b00; rect0 = '0; rect1 = '0; color0 = '0; color1 = '0;
        reinit = 1'b0; tft_done = 1'b0; tft_busy = 1'b0; tft_cnext = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_init", tft_init, 0);
        chk("rst_draw", tft_draw, 0);
        chk("rst_coords", {tft_xstart, tft_xend, tft_ystart, tft_yend}, 0);
        chk("rst_ready", ready, 0);

        // Init sequence driven by hand: done arrives at cycle 50.
        rst = 1'b0;
        ninit = 0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            if (tft_init) ninit++;
        end
        chk("init_once", ninit, 1);
        chk("ready_initwait", ready, 0);
        tft_done = 1'b1;
        @(negedge clk);
        tft_done = 1'b0;
        chk("ready_gap1", ready, 0);
        @(negedge clk);
        chk("ready_gap2", ready, 0);
        @(negedge clk);
        chk("ready_after_gap", ready, 1);

        fork
            ctrl_loop();
        join_none

        // Both requesters at once: 0 wins the first tie, then 1.
        run_pattern(2'b11, 64'h0001_0010_0002_0020, 64'h0003_0030_0004_0040, 16'hF800, 16'h07E0);

        // Randomized mix of single and tied requests.
        for (int t = 0; t < 30; t++) begin
            run_pattern(2'($urandom_range(1, 3)), rnd_rect(), rnd_rect(),
                        16'($urandom), 16'($urandom));
        end

        // req[0] held while req[1] pulses: grants go 0,1,0.
        wait_for(2, "ready_before_fair");
        ra = 64'h0005_0050_0006_0060;
        rb = 64'h0007_0070_0008_0080;
        rect0 = ra; rect1 = rb; color0 = 16'h1234; color1 = 16'h5678;
        push_exp(pick(2'b01), ra, 16'h1234);
        push_exp(pick(2'b11), rb, 16'h5678);
        push_exp(pick(2'b01), ra, 16'h1234);
        req = 2'b01;
        wait_for(3, "fair_first_gnt");
        req[1] = 1'b1;
        n0 = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack[1]) req[1] = 1'b0;
            if (ack[0]) begin
                n0++;
                if (n0 == 2) req[0] = 1'b0;
            end
            if (req == 2'b00) break;
        end
        chk("fair_done", req, 0);
        req = 2'b00;

        // reinit during a draw: draw completes, then init before any new grant.
        push_exp(pick(2'b01), ra, 16'h1234);
        req = 2'b01;
        wait_for(0, "reinit_draw_seen");
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack[0]) break;
        end
        req = 2'b00;
        push_exp(pick(2'b10), rb, 16'h5678);
        req = 2'b10;
        saw_init  = 1'b0;
        early_gnt = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tft_init) saw_init = 1'b1;
            if (gnt != 2'b00 && !saw_init) early_gnt = 1'b1;
            if (ack[1]) begin
                req = 2'b00;
                break;
            end
        end
        chk("reinit_init_seen", saw_init, 1);
        chk("reinit_no_early_gnt", early_gnt, 0);
        req = 2'b00;

`ifdef TFT_DRAW_ARB_CLIP_EN
        run_pattern(2'b01, {16'd0, 16'd300, 16'd10, 16'd400}, rb, 16'h00FF, 16'h5678);
        chk("clip_xend", tft_xend, 239);
        chk("clip_yend", tft_yend, 319);
        run_pattern(2'b01, {16'd250, 16'd260, 16'd0, 16'd5}, rb, 16'h00FF, 16'h5678);
`endif

        // Reset 3 cycles after a draw: transaction abandoned, no ack.
        wait_for(2, "ready_before_rst");
        push_exp(pick(2'b01), ra, 16'h1234);
        req = 2'b01;
        wait_for(0, "rst_draw_seen");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_ready", ready, 0);
        ack_q.delete();
        model_last = 1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_init_pulse", tft_init, 1);
        wait_for(2, "ready_after_rst");
        run_pattern(2'b11, ra, rb, 16'h1111, 16'h2222);

        repeat (5) @(negedge clk);
        chk("draw_q_empty", draw_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tft_draw_arb.md
TFT_DRAW_ARB -- requirements
Module: tft_draw_arb

Interface
REQ-001 SHALL provide parameter CLIP_XMAX, default 239, maximum legal column index.
REQ-002 SHALL provide parameter CLIP_YMAX, default 319, maximum legal row index.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  2  per-requester draw request, level; bit i = requester i.
REQ-006 rect0, rect1  in  64 each  {xstart,xend,ystart,yend}, 16b fields, MSB first.
REQ-007 color0, color1  in  16 each  RGB565 pixel color of requester i.
REQ-008 gnt  out  2  one-hot grant; bit i high while requester i's draw is in flight.
REQ-009 ack  out  2  one-cycle pulse to requester i when its draw completes or is rejected.
REQ-010 err  out  1  qualifies ack; high for one cycle with ack when the request was rejected.
REQ-011 cnext_o  out  2  tft cnext routed to the granted requester; 0 for the other.
REQ-012 reinit  in  1  one-cycle pulse requesting a fresh display init sequence.
REQ-013 ready  out  1  high when init is complete and the arbiter is idle.
REQ-014 tft_init, tft_draw  out  1 each  one-cycle command pulses to the TFT controller.
REQ-015 tft_xstart, tft_xend, tft_ystart, tft_yend  out  16 each  rectangle to the controller.
REQ-016 tft_color  out  16  color to the controller; combinationally muxed from the granted requester.
REQ-017 tft_busy, tft_done, tft_cnext  in  1 each  status from the controller.

Function
REQ-018 States: BOOT, INITWAIT, GAP, IDLE, DRAWWAIT; the FSM SHALL use exactly these states.
REQ-019 BOOT SHALL pulse tft_init for one cycle and move to INITWAIT.
REQ-020 INITWAIT SHALL hold until tft_done, then move to GAP.
REQ-021 GAP SHALL last exactly 2 cycles, covering the controller's post-done return to idle, then move to IDLE.
REQ-022 In IDLE, a pending reinit SHALL take priority over draw requests and move the FSM to BOOT.
REQ-023 A reinit pulse arriving in any state other than IDLE SHALL be latched and serviced on the next IDLE.
REQ-024 In IDLE with a single req bit set, that requester SHALL be granted.
REQ-025 In IDLE with both req bits set, the requester not served last SHALL be granted (round-robin).
REQ-026 The last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-027 On grant, the rect SHALL be registered into tft_x*/tft_y*, gnt SHALL be set, and tft_draw SHALL pulse in the same cycle that gnt rises; the FSM then moves to DRAWWAIT.
REQ-028 tft_x*/tft_y* SHALL stay stable until the next grant.
REQ-029 DRAWWAIT SHALL wait for tft_done, then pulse ack[i], clear gnt, update the last-served pointer, and go to GAP.
REQ-030 Requesters SHALL hold req until ack; a req drop during DRAWWAIT SHALL NOT abort the draw.
REQ-031 ready SHALL equal (state==IDLE) with no reinit pending.
REQ-032 tft_busy is informational only; an unexpected tft_done outside INITWAIT/DRAWWAIT SHALL be ignored.

Reset
REQ-033 On rst: state=BOOT, gnt=0, ack=0, err=0, tft_init=0, tft_draw=0, tft_* coordinates=0, reinit latch cleared, pointer=1, ready=0.
REQ-034 rst asserted mid-draw SHALL abandon the transaction without issuing ack and SHALL restart from BOOT.

Configuration
REQ-035 Macro TFT_DRAW_ARB_CLIP_EN SHALL control rectangle clipping.
REQ-036 With TFT_DRAW_ARB_CLIP_EN defined: xend is clamped to CLIP_XMAX and yend to CLIP_YMAX before registering.
REQ-037 With TFT_DRAW_ARB_CLIP_EN defined: if xstart>xend or ystart>yend after clamping, no tft_draw is issued; ack[i] and err SHALL pulse in the cycle after grant, and the FSM returns to IDLE.
REQ-038 Without TFT_DRAW_ARB_CLIP_EN: rectangles pass unmodified and err SHALL be tied to 0.

Verification
REQ-039 Release rst -> tft_init pulses once; tft_done at cycle 50 -> ready rises 2 cycles later.
REQ-040 Both req high together after init -> gnt=01, ack[0]; then gnt=10, ack[1]; draws separated by at least 2 idle cycles.
REQ-041 req[0] held high continuously while req[1] pulses -> grants alternate 0,1,0 with no starvation.
REQ-042 reinit pulsed during DRAWWAIT -> the current draw completes with ack, then tft_init pulses before any further grant.
REQ-043 CLIP_EN, rect0={0,300,10,400} -> tft_xend=239, tft_yend=319; rect0={250,260,0,5} -> ack[0]+err, no tft_draw.
REQ-044 rst asserted 3 cycles after tft_draw -> no ack, gnt=0, FSM in BOOT, tft_init pulses after rst falls.
